// File: rtl/rv_ctrl_defs.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, ALU operation
// codes, operand/writeback selects, FSM states and the bundled control word.
package rv_ctrl_defs;

    typedef enum logic [3:0] {
        ST_FETCH      = 4'd0,
        ST_DECODE     = 4'd1,
        ST_EXEC_R     = 4'd2,
        ST_EXEC_I     = 4'd3,
        ST_EXEC_LUI   = 4'd4,
        ST_EXEC_AUIPC = 4'd5,
        ST_WB_ALU     = 4'd6,
        ST_MEM_ADDR   = 4'd7,
        ST_MEM_RD     = 4'd8,
        ST_MEM_WR     = 4'd9,
        ST_WB_MEM     = 4'd10,
        ST_BRANCH     = 4'd11,
        ST_JAL        = 4'd12,
        ST_JALR       = 4'd13,
        ST_TRAP       = 4'd14
    } state_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // ula_op codes, also consumed by ula_control
    localparam logic [2:0] ULA_ADD    = 3'b000;
    localparam logic [2:0] ULA_BRANCH = 3'b001;
    localparam logic [2:0] ULA_RTYPE  = 3'b010;
    localparam logic [2:0] ULA_ITYPE  = 3'b011;
    localparam logic [2:0] ULA_LUI    = 3'b100;
    localparam logic [2:0] ULA_AUIPC  = 3'b101;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] WB_SEL_ALUOUT = 2'b00;
    localparam logic [1:0] WB_SEL_MEM    = 2'b01;
    localparam logic [1:0] WB_SEL_PC     = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [1:0] ula_src_a;
        logic [1:0] ula_src_b;
        logic [2:0] ula_op;
        logic       illegal_inst;
        logic       mem_timeout;
        logic       instr_done;
    } ctrl_t;

    function automatic state_t decode_next(input logic [6:0] opc);
        state_t st;
        case (opc)
            OPC_R:               st = ST_EXEC_R;
            OPC_I:               st = ST_EXEC_I;
            OPC_LOAD, OPC_STORE: st = ST_MEM_ADDR;
            OPC_BRANCH:          st = ST_BRANCH;
            OPC_LUI:             st = ST_EXEC_LUI;
            OPC_AUIPC:           st = ST_EXEC_AUIPC;
            OPC_JAL:             st = ST_JAL;
            OPC_JALR:            st = ST_JALR;
            default:             st = ST_TRAP;
        endcase
        return st;
    endfunction

    // States that sit on the memory port waiting for mem_ready
    function automatic logic is_wait_state(input state_t st);
        return (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// Stall counter for memory-wait states: cleared on entry to a wait state,
// counts cycles without mem_ready, and flags when the count reaches the limit.
module ctrl_watchdog #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_at_limit
);

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_count_en) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_at_limit = (r_count == LIMIT);

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle main control FSM for the RV32I core: sequences fetch/decode/execute/
// memory/writeback over a shared ALU and one memory port with a stall watchdog.
module unidade_controle_multiciclo
    import rv_ctrl_defs::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [1:0] ula_src_a,
    output logic [1:0] ula_src_b,
    output logic [2:0] ula_op,
    output logic       illegal_inst,
    output logic       mem_timeout,
    output logic       instr_done,
    output logic [3:0] state_dbg
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;
    logic   w_wait_state;
    logic   w_at_limit;
    logic   w_expired;
    logic   w_wd_clear;
    logic   w_wd_count_en;

    assign w_wait_state  = is_wait_state(r_state);
    assign w_expired     = w_wait_state && w_at_limit && !mem_ready;
    assign w_wd_count_en = w_wait_state && !mem_ready;
    // A timed-out fetch loops back into FETCH and must still restart the count
    assign w_wd_clear    = is_wait_state(w_next_state) &&
                           ((w_next_state != r_state) || w_expired);

    ctrl_watchdog #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_wd_clear),
        .i_count_en(w_wd_count_en),
        .o_at_limit(w_at_limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH:      w_next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE:     w_next_state = decode_next(opcode);
            ST_EXEC_R,
            ST_EXEC_I,
            ST_EXEC_LUI,
            ST_EXEC_AUIPC: w_next_state = ST_WB_ALU;
            ST_WB_ALU:     w_next_state = ST_FETCH;
            ST_MEM_ADDR:   w_next_state = (opcode == OPC_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (mem_ready) begin
                    w_next_state = ST_WB_MEM;
                end else if (w_expired) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_MEM_WR: begin
                if (mem_ready || w_expired) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_WB_MEM,
            ST_BRANCH,
            ST_JAL,
            ST_JALR,
            ST_TRAP:       w_next_state = ST_FETCH;
            default:       w_next_state = ST_FETCH;
        endcase
    end

    always_comb begin
        w_ctrl = '0;
        case (r_state)
            ST_FETCH: begin
                w_ctrl.mem_req     = 1'b1;
                w_ctrl.addr_sel    = 1'b0;
                w_ctrl.ula_src_a   = SRC_A_PC;
                w_ctrl.ula_src_b   = SRC_B_FOUR;
                w_ctrl.ula_op      = ULA_ADD;
                w_ctrl.pc_src      = 1'b0;
                w_ctrl.ir_write    = mem_ready;
                w_ctrl.pc_write    = mem_ready;
                w_ctrl.mem_timeout = w_expired;
            end
            ST_DECODE: begin
                w_ctrl.ula_src_a = SRC_A_OLD_PC;
                w_ctrl.ula_src_b = SRC_B_IMM;
                w_ctrl.ula_op    = ULA_ADD;
            end
            ST_EXEC_R: begin
                w_ctrl.ula_src_a = SRC_A_RS1;
                w_ctrl.ula_src_b = SRC_B_RS2;
                w_ctrl.ula_op    = ULA_RTYPE;
            end
            ST_EXEC_I: begin
                w_ctrl.ula_src_a = SRC_A_RS1;
                w_ctrl.ula_src_b = SRC_B_IMM;
                w_ctrl.ula_op    = ULA_ITYPE;
            end
            ST_EXEC_LUI: begin
                w_ctrl.ula_src_a = SRC_A_ZERO;
                w_ctrl.ula_src_b = SRC_B_IMM;
                w_ctrl.ula_op    = ULA_LUI;
            end
            ST_EXEC_AUIPC: begin
                w_ctrl.ula_src_a = SRC_A_OLD_PC;
                w_ctrl.ula_src_b = SRC_B_IMM;
                w_ctrl.ula_op    = ULA_AUIPC;
            end
            ST_WB_ALU: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.wb_sel     = WB_SEL_ALUOUT;
                w_ctrl.instr_done = 1'b1;
            end
            ST_MEM_ADDR: begin
                w_ctrl.ula_src_a = SRC_A_RS1;
                w_ctrl.ula_src_b = SRC_B_IMM;
                w_ctrl.ula_op    = ULA_ADD;
            end
            ST_MEM_RD: begin
                w_ctrl.mem_req     = 1'b1;
                w_ctrl.addr_sel    = 1'b1;
                w_ctrl.mem_timeout = w_expired;
            end
            ST_MEM_WR: begin
                w_ctrl.mem_req     = 1'b1;
                w_ctrl.mem_we      = 1'b1;
                w_ctrl.addr_sel    = 1'b1;
                w_ctrl.instr_done  = mem_ready;
                w_ctrl.mem_timeout = w_expired;
            end
            ST_WB_MEM: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.wb_sel     = WB_SEL_MEM;
                w_ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                w_ctrl.ula_src_a  = SRC_A_RS1;
                w_ctrl.ula_src_b  = SRC_B_RS2;
                w_ctrl.ula_op     = ULA_BRANCH;
                w_ctrl.pc_src     = 1'b1;
                w_ctrl.pc_write   = branch_taken;
                w_ctrl.instr_done = 1'b1;
            end
            ST_JAL: begin
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_src     = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.wb_sel     = WB_SEL_PC;
                w_ctrl.instr_done = 1'b1;
            end
            ST_JALR: begin
                w_ctrl.ula_src_a  = SRC_A_RS1;
                w_ctrl.ula_src_b  = SRC_B_IMM;
                w_ctrl.ula_op     = ULA_ADD;
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_src     = 1'b0;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.wb_sel     = WB_SEL_PC;
                w_ctrl.instr_done = 1'b1;
            end
            ST_TRAP: begin
                w_ctrl.illegal_inst = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
        // Outputs go quiet the moment reset asserts, even mid-access
        if (!rst_n) begin
            w_ctrl = '0;
        end
    end

    assign mem_req      = w_ctrl.mem_req;
    assign mem_we       = w_ctrl.mem_we;
    assign addr_sel     = w_ctrl.addr_sel;
    assign ir_write     = w_ctrl.ir_write;
    assign pc_write     = w_ctrl.pc_write;
    assign pc_src       = w_ctrl.pc_src;
    assign reg_write    = w_ctrl.reg_write;
    assign wb_sel       = w_ctrl.wb_sel;
    assign ula_src_a    = w_ctrl.ula_src_a;
    assign ula_src_b    = w_ctrl.ula_src_b;
    assign ula_op       = w_ctrl.ula_op;
    assign illegal_inst = w_ctrl.illegal_inst;
    assign mem_timeout  = w_ctrl.mem_timeout;
    assign instr_done   = w_ctrl.instr_done;
    assign state_dbg    = r_state;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multi-cycle control unit; every cycle's full output word
// is compared against a hand-written expected vector.
module tb_unidade_controle_multiciclo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] wb_sel, ula_src_a, ula_src_b;
    logic [2:0] ula_op;
    logic       illegal_inst, mem_timeout, instr_done;
    logic [3:0] state_dbg;
    logic [22:0] obs;

    int checks = 0;
    int errors = 0;

    logic [22:0] F_RDY, F_W, F_TO, DEC, EX_R, EX_I, EX_LUI, EX_AUI, WB_A, MA;
    logic [22:0] RD, WR, WR_DONE, WR_TO, WBM, BR_T, BR_N, JAL_V, JALR_V, TRAP_V;

    always #5 clk = ~clk;

    unidade_controle_multiciclo #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .wb_sel(wb_sel), .ula_src_a(ula_src_a), .ula_src_b(ula_src_b), .ula_op(ula_op),
        .illegal_inst(illegal_inst), .mem_timeout(mem_timeout), .instr_done(instr_done),
        .state_dbg(state_dbg)
    );

    assign obs = {state_dbg, mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
                  reg_write, wb_sel, ula_src_a, ula_src_b, ula_op, illegal_inst,
                  mem_timeout, instr_done};

    function automatic logic [22:0] ov(input logic [3:0] st, input logic req, we, asel,
                                       irw, pcw, pcs, rw, input logic [1:0] wb, sa, sb,
                                       input logic [2:0] op, input logic ill, to, dn);
        return {st, req, we, asel, irw, pcw, pcs, rw, wb, sa, sb, op, ill, to, dn};
    endfunction

    task automatic init_vectors();
        //          st   req we as ir pw ps rw  wb    sa    sb    op    il to dn
        F_RDY   = ov(0,  1, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd1, 3'd0, 0, 0, 0);
        F_W     = ov(0,  1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd0, 0, 0, 0);
        F_TO    = ov(0,  1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd0, 0, 1, 0);
        DEC     = ov(1,  0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 3'd0, 0, 0, 0);
        EX_R    = ov(2,  0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 3'd2, 0, 0, 0);
        EX_I    = ov(3,  0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd3, 0, 0, 0);
        EX_LUI  = ov(4,  0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd2, 3'd4, 0, 0, 0);
        EX_AUI  = ov(5,  0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 3'd5, 0, 0, 0);
        WB_A    = ov(6,  0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 0, 0, 1);
        MA      = ov(7,  0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 0, 0, 0);
        RD      = ov(8,  1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 0, 0);
        WR      = ov(9,  1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 0, 0);
        WR_DONE = ov(9,  1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 0, 1);
        WR_TO   = ov(9,  1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 1, 0);
        WBM     = ov(10, 0, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 0, 0, 1);
        BR_T    = ov(11, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd1, 2'd0, 3'd1, 0, 0, 1);
        BR_N    = ov(11, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd1, 2'd0, 3'd1, 0, 0, 1);
        JAL_V   = ov(12, 0, 0, 0, 0, 1, 1, 1, 2'd2, 2'd0, 2'd0, 3'd0, 0, 0, 1);
        JALR_V  = ov(13, 0, 0, 0, 0, 1, 0, 1, 2'd2, 2'd1, 2'd2, 3'd0, 0, 0, 1);
        TRAP_V  = ov(14, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 1, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; opcode = 7'd0;
        #12;
        checks++;
        if (obs !== 23'd0) begin
            errors++; $display("FAIL reset_hold: got %h, expected %h", obs, 23'd0);
        end
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== F_W) begin
            errors++; $display("FAIL reset_release: got %h, expected %h", obs, F_W);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_add();
        logic [22:0] e[$];
        logic r[$];
        e = '{F_RDY, DEC, EX_R, WB_A, F_W};
        r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 7'b0110011;
        for (int i = 0; i < e.size(); i++) begin
            mem_ready = r[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++; $display("FAIL add cycle %0d: got %h, expected %h", i, obs, e[i]);
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_load_delay();
        logic [22:0] e[$];
        logic r[$];
        e = '{F_RDY, DEC, MA, RD, RD, RD, RD, WBM, F_W};
        r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        opcode = 7'b0000011;
        for (int i = 0; i < e.size(); i++) begin
            mem_ready = r[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++; $display("FAIL load_delay cycle %0d: got %h, expected %h", i, obs, e[i]);
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_branch();
        logic [22:0] e[$];
        logic r[$];
        logic t[$];
        e = '{F_RDY, DEC, BR_T, F_RDY, DEC, BR_N, F_W};
        r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 7'b1100011;
        for (int i = 0; i < e.size(); i++) begin
            mem_ready = r[i];
            branch_taken = t[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++; $display("FAIL branch cycle %0d: got %h, expected %h", i, obs, e[i]);
            end
            @(posedge clk); #2;
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_jumps_upper();
        logic [22:0] e[$];
        logic r[$];
        logic [6:0] o[$];
        e = '{F_RDY, DEC, JAL_V, F_RDY, DEC, JALR_V, F_RDY, DEC, EX_LUI, WB_A,
              F_RDY, DEC, EX_AUI, WB_A, F_RDY, DEC, EX_I, WB_A, F_W};
        r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        o = '{7'b1101111, 7'b1101111, 7'b1101111, 7'b1100111, 7'b1100111, 7'b1100111,
              7'b0110111, 7'b0110111, 7'b0110111, 7'b0110111, 7'b0010111, 7'b0010111,
              7'b0010111, 7'b0010111, 7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011,
              7'b0010011};
        for (int i = 0; i < e.size(); i++) begin
            mem_ready = r[i];
            opcode = o[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++; $display("FAIL jumps_upper cycle %0d: got %h, expected %h", i, obs, e[i]);
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_trap();
        logic [22:0] e[$];
        logic r[$];
        e = '{F_RDY, DEC, TRAP_V, F_W};
        r = '{1'b1, 1'b0, 1'b0, 1'b0};
        opcode = 7'b1111111;
        for (int i = 0; i < e.size(); i++) begin
            mem_ready = r[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++; $display("FAIL trap cycle %0d: got %h, expected %h", i, obs, e[i]);
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_store_timeout();
        logic [22:0] e[$];
        logic r[$];
        e = '{F_RDY, DEC, MA, WR, WR, WR, WR, WR_TO, F_W};
        r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 7'b0100011;
        for (int i = 0; i < e.size(); i++) begin
            mem_ready = r[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++; $display("FAIL store_timeout cycle %0d: got %h, expected %h", i, obs, e[i]);
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_ready_on_limit();
        logic [22:0] e[$];
        logic r[$];
        e = '{F_RDY, DEC, MA, RD, RD, RD, RD, RD, WBM, F_W};
        r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        opcode = 7'b0000011;
        for (int i = 0; i < e.size(); i++) begin
            mem_ready = r[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++; $display("FAIL ready_on_limit cycle %0d: got %h, expected %h", i, obs, e[i]);
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_back_to_back();
        logic [22:0] e[$];
        logic r[$];
        logic [6:0] o[$];
        e = '{F_RDY, DEC, MA, WR_DONE, F_RDY, DEC, EX_R, WB_A, F_W};
        r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        o = '{7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011, 7'b0110011,
              7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011};
        for (int i = 0; i < e.size(); i++) begin
            mem_ready = r[i];
            opcode = o[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++; $display("FAIL back_to_back cycle %0d: got %h, expected %h", i, obs, e[i]);
            end
            @(posedge clk); #2;
        end
    endtask

    // Entered with one FETCH wait cycle already counted by the previous task
    task automatic test_fetch_timeout();
        logic [22:0] e[$];
        logic r[$];
        e = '{F_W, F_W, F_W, F_TO, F_W, F_W, F_W, F_W, F_TO, F_RDY, DEC, EX_I, WB_A, F_W};
        r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 7'b0010011;
        for (int i = 0; i < e.size(); i++) begin
            mem_ready = r[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++; $display("FAIL fetch_timeout cycle %0d: got %h, expected %h", i, obs, e[i]);
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [22:0] e[$];
        logic r[$];
        e = '{F_RDY, DEC, MA, RD, RD};
        r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 7'b0000011;
        for (int i = 0; i < e.size(); i++) begin
            mem_ready = r[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++; $display("FAIL reset_mid_wait cycle %0d: got %h, expected %h", i, obs, e[i]);
            end
            @(posedge clk); #2;
        end
        checks++;
        if (obs !== RD) begin
            errors++; $display("FAIL reset_mid_wait pre: got %h, expected %h", obs, RD);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 23'd0) begin
            errors++; $display("FAIL reset_mid_wait async: got %h, expected %h", obs, 23'd0);
        end
        @(posedge clk); #2;
        checks++;
        if (obs !== 23'd0) begin
            errors++; $display("FAIL reset_mid_wait held: got %h, expected %h", obs, 23'd0);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== F_W) begin
            errors++; $display("FAIL reset_mid_wait release: got %h, expected %h", obs, F_W);
        end
        @(posedge clk); #2;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete in time");
        $fatal(1, "global timeout");
    end

    initial begin
        init_vectors();
        test_reset();
        test_add();
        test_load_delay();
        test_branch();
        test_jumps_upper();
        test_trap();
        test_store_timeout();
        test_ready_on_limit();
        test_back_to_back();
        test_fetch_timeout();
        test_reset_mid_wait();
        test_add();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
